// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage pipeline. Holds the program counter,
// drives the instruction-memory address and latches the returned word into
// the IF/ID pipeline register. Redirects from EX (branch) and ID (jump)
// flush IF/ID with a NOP bubble; a load-use stall from the hazard unit
// freezes PC and IF/ID. A three-state controller adds one BOOT cycle after
// reset before the first fetch.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   PC_Write       in   1   1 = advance, 0 = stall (hold PC and IF/ID)
//   Branch_taken   in   1   redirect request from EX (highest priority)
//   Branch_target  in  32   branch destination byte address
//   Jump           in   1   redirect request from ID
//   Jump_target    in  32   jump destination byte address
//   Instruction    in  32   instruction memory read data for Instr_addr
//   Instr_addr     out 32   current PC (word aligned)
//   IF_ID_Instr    out 32   latched instruction (0 = NOP bubble)
//   IF_ID_PC4      out 32   PC+4 belonging to IF_ID_Instr
//   IF_ID_Valid    out  1   1 = IF_ID_Instr is a real instruction
//   Fetch_count    out 32   instructions latched into IF/ID (wraps)
//   Stall_count    out 16   stall cycles seen (saturates)
//   State          out  2   BOOT=00, RUN=01, HOLD=10
// ---------------------------------------------------------------------------
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic        Jump,
    input  logic [31:0] Jump_target,
    input  logic [31:0] Instruction,
    output logic [31:0] Instr_addr,
    output logic [31:0] IF_ID_Instr,
    output logic [31:0] IF_ID_PC4,
    output logic        IF_ID_Valid,
    output logic [31:0] Fetch_count,
    output logic [15:0] Stall_count,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [31:0] pc4_r;
    logic        valid_r;
    logic [31:0] fetch_cnt_r;
    logic [15:0] stall_cnt_r;

    state_t      state_s;
    logic [31:0] pc_s;
    logic [31:0] instr_s;
    logic [31:0] pc4_s;
    logic        valid_s;
    logic [31:0] fetch_cnt_s;
    logic [15:0] stall_cnt_s;
    logic [31:0] pc_plus4_s;

    // PC+4 wraps naturally modulo 2^32
    assign pc_plus4_s = pc_r + 32'd4;

    // Next-state and next-register selection: branch > jump > stall > advance
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        instr_s     = instr_r;
        pc4_s       = pc4_r;
        valid_s     = valid_r;
        fetch_cnt_s = fetch_cnt_r;
        stall_cnt_s = stall_cnt_r;
        case (state_r)
            RUN, HOLD: begin
                if (Branch_taken) begin
                    // Flush beats stall; low address bits forced to word alignment
                    pc_s    = {Branch_target[31:2], 2'b00};
                    instr_s = 32'h0000_0000;
                    pc4_s   = 32'h0000_0000;
                    valid_s = 1'b0;
                    state_s = RUN;
                end else if (Jump) begin
                    pc_s    = {Jump_target[31:2], 2'b00};
                    instr_s = 32'h0000_0000;
                    pc4_s   = 32'h0000_0000;
                    valid_s = 1'b0;
                    state_s = RUN;
                end else if (!PC_Write) begin
                    if (stall_cnt_r != 16'hFFFF) begin
                        stall_cnt_s = stall_cnt_r + 16'd1;
                    end else begin
                        stall_cnt_s = stall_cnt_r;
                    end
                    state_s = HOLD;
                end else begin
                    pc_s        = pc_plus4_s;
                    instr_s     = Instruction;
                    pc4_s       = pc_plus4_s;
                    valid_s     = 1'b1;
                    fetch_cnt_s = fetch_cnt_r + 32'd1;
                    state_s     = RUN;
                end
            end
            default: begin
                // BOOT and the unreachable encoding: park PC at 0, ignore inputs
                pc_s    = 32'h0000_0000;
                state_s = RUN;
            end
        endcase
    end

    // Pipeline, PC, counter and state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= BOOT;
            pc_r        <= 32'h0000_0000;
            instr_r     <= 32'h0000_0000;
            pc4_r       <= 32'h0000_0000;
            valid_r     <= 1'b0;
            fetch_cnt_r <= 32'h0000_0000;
            stall_cnt_r <= 16'h0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            instr_r     <= instr_s;
            pc4_r       <= pc4_s;
            valid_r     <= valid_s;
            fetch_cnt_r <= fetch_cnt_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign Instr_addr  = pc_r;
    assign IF_ID_Instr = instr_r;
    assign IF_ID_PC4   = pc4_r;
    assign IF_ID_Valid = valid_r;
    assign Fetch_count = fetch_cnt_r;
    assign Stall_count = stall_cnt_r;
    assign State       = state_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. Directed scenarios cover boot, stall,
// redirect priority, alignment, PC wrap, stall-counter saturation and async
// reset; a randomized phase is compared against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        PC_Write;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        Jump;
    logic [31:0] Jump_target;
    logic [31:0] Instruction;
    logic [31:0] Instr_addr;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [31:0] Fetch_count;
    logic [15:0] Stall_count;
    logic [1:0]  State;

    int unsigned n_checks;
    int unsigned n_fails;

    // Reference model state (0 = BOOT, 1 = RUN, 2 = HOLD)
    int unsigned m_state;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_fcnt;
    int unsigned m_scnt;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PC_Write      (PC_Write),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .Jump          (Jump),
        .Jump_target   (Jump_target),
        .Instruction   (Instruction),
        .Instr_addr    (Instr_addr),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PC4     (IF_ID_PC4),
        .IF_ID_Valid   (IF_ID_Valid),
        .Fetch_count   (Fetch_count),
        .Stall_count   (Stall_count),
        .State         (State)
    );

    // Instruction memory contents: fixed word at 0, hashed pattern elsewhere
    function automatic logic [31:0] imem(input logic [31:0] addr);
        if (addr == 32'h0000_0000) return 32'h2008_0005;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    assign Instruction = imem(Instr_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_valid = 1'b0; m_fcnt = 32'h0; m_scnt = 0;
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".addr"},  Instr_addr, m_pc);
        check_eq({tag, ".instr"}, IF_ID_Instr, m_instr);
        check_eq({tag, ".pc4"},   IF_ID_PC4, m_pc4);
        check_eq({tag, ".valid"}, {31'h0, IF_ID_Valid}, {31'h0, m_valid});
        check_eq({tag, ".fcnt"},  Fetch_count, m_fcnt);
        check_eq({tag, ".scnt"},  {16'h0, Stall_count}, m_scnt);
        check_eq({tag, ".state"}, {30'h0, State}, m_state);
    endtask

    // One clock: apply inputs, advance the model by the stated rules, compare
    task automatic step(input string tag, input logic pw, input logic bt,
                        input logic [31:0] btgt, input logic jp, input logic [31:0] jtgt);
        PC_Write = pw; Branch_taken = bt; Branch_target = btgt;
        Jump = jp; Jump_target = jtgt;
        if (m_state == 0) begin
            m_pc = 32'h0; m_state = 1;
        end else if (bt || jp) begin
            m_pc = (bt ? btgt : jtgt) & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_state = 1;
        end else if (!pw) begin
            if (m_scnt < 65535) m_scnt = m_scnt + 1;
            m_state = 2;
        end else begin
            m_instr = imem(m_pc);
            m_pc = m_pc + 32'd4;
            m_pc4 = m_pc;
            m_valid = 1'b1;
            m_fcnt = m_fcnt + 32'd1;
            m_state = 1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0; PC_Write = 1'b1; Branch_taken = 1'b0; Branch_target = 32'h0;
        Jump = 1'b0; Jump_target = 32'h0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Boot then first fetch
        step("boot", 1'b1, 1'b1, 32'h0000_1230, 1'b1, 32'h0000_4560);
        check_eq("boot_state", {30'h0, State}, 32'd1);
        check_eq("boot_addr", Instr_addr, 32'h0);
        step("fetch0", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("fetch0_instr", IF_ID_Instr, 32'h2008_0005);
        check_eq("fetch0_pc4", IF_ID_PC4, 32'h4);
        check_eq("fetch0_addr", Instr_addr, 32'h4);
        check_eq("fetch0_fcnt", Fetch_count, 32'h1);

        // Stall for three cycles at PC=8, then resume
        step("adv4", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("stall_pc", Instr_addr, 32'h8);
        check_eq("stall_state", {30'h0, State}, 32'd2);
        check_eq("stall_cnt", {16'h0, Stall_count}, 32'd3);
        step("resume", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("resume_pc", Instr_addr, 32'hC);
        check_eq("resume_state", {30'h0, State}, 32'd1);

        // Branch and jump together during a stall: branch wins, no stall counted
        step("adv16", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("br_jp", 1'b0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080);
        check_eq("br_pc", Instr_addr, 32'h40);
        check_eq("br_instr", IF_ID_Instr, 32'h0);
        check_eq("br_scnt", {16'h0, Stall_count}, 32'd3);

        // Alignment and PC wrap
        step("jmp_align", 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0103);
        check_eq("jmp_align_pc", Instr_addr, 32'h100);
        step("jmp_top", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        step("wrap", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("wrap_pc", Instr_addr, 32'h0);
        check_eq("wrap_pc4", IF_ID_PC4, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            r = $urandom;
            step("rand", (r[1:0] != 2'b00), (r[4:2] == 3'b000), $urandom,
                 (r[7:5] == 3'b000), $urandom);
        end

        // Stall counter saturation
        for (int i = 0; i < 65540; i++) step("sat", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("sat_cnt", {16'h0, Stall_count}, 32'h0000_FFFF);

        // Asynchronous reset pulse between edges, during a pending stall
        @(negedge clk);
        PC_Write = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        rst_n = 1'b1;
        step("boot2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step("fetch2", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check_eq("fetch2_instr", IF_ID_Instr, 32'h2008_0005);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: PC_Write  input  1  1 = advance PC and IF/ID; 0 = hold (load-use stall from hazard unit).
REQ-004 SHALL have: Branch_taken  input  1  redirect request from EX stage.
REQ-005 SHALL have: Branch_target  input  32  branch destination byte address.
REQ-006 SHALL have: Jump  input  1  redirect request from ID stage.
REQ-007 SHALL have: Jump_target  input  32  jump destination byte address.
REQ-008 SHALL have: Instruction  input  32  IM read data, combinational from Instr_addr.
REQ-009 SHALL have: Instr_addr  output  32  current PC, drives IM address.
REQ-010 SHALL have: IF_ID_Instr  output  32  registered instruction to ID.
REQ-011 SHALL have: IF_ID_PC4  output  32  registered PC+4 of IF_ID_Instr.
REQ-012 SHALL have: IF_ID_Valid  output  1  1 = IF_ID_Instr is real; 0 = bubble.
REQ-013 SHALL have: Fetch_count  output  32  count of instructions latched into IF/ID.
REQ-014 SHALL have: Stall_count  output  16  count of stall cycles.
REQ-015 SHALL have: State  output  2  FSM state: BOOT=00, RUN=01, HOLD=10.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HOLD; 11 unreachable, treated as BOOT on next edge.
REQ-017 BOOT SHALL last exactly one clock after rst_n deasserts: PC held at 0, IF/ID unchanged, all inputs ignored; next state RUN.
REQ-018 Per-edge priority in RUN/HOLD SHALL be: Branch_taken > Jump > stall (PC_Write=0) > normal advance.
REQ-019 Normal advance: PC <= PC+4; IF_ID_Instr <= Instruction; IF_ID_PC4 <= PC+4; IF_ID_Valid <= 1; Fetch_count +1; next state RUN.
REQ-020 Stall: PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, Fetch_count held; Stall_count +1; next state HOLD.
REQ-021 Branch redirect: PC <= {Branch_target[31:2],2'b00}; IF_ID_Instr <= 32'h0 (NOP); IF_ID_PC4 <= 0; IF_ID_Valid <= 0; counters unchanged; next state RUN.
REQ-022 Jump redirect: identical to REQ-021 using Jump_target.
REQ-023 Redirect SHALL override PC_Write=0 in the same cycle (flush beats stall); Stall_count not incremented.
REQ-024 Branch_taken and Jump both high: Branch_target used; Jump ignored.
REQ-025 Instr_addr SHALL equal PC combinationally; Instr_addr[1:0] always 00.
REQ-026 PC+4 SHALL be modulo 2^32: PC 32'hFFFF_FFFC advances to 32'h0000_0000, IF_ID_PC4 = 0.
REQ-027 Fetch_count SHALL wrap FFFF_FFFF -> 0; Stall_count SHALL saturate at 16'hFFFF.
REQ-028 HOLD -> RUN on any edge with PC_Write=1 or a redirect; remains HOLD while PC_Write=0 and no redirect.
REQ-029 Latency: instruction at address A appears on IF_ID_Instr one edge after Instr_addr=A with PC_Write=1 and no redirect.

Reset
REQ-030 rst_n low SHALL immediately (no clock) set PC=0, IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0, Fetch_count=0, Stall_count=0, State=BOOT.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard pending action; outputs per REQ-030 while held.
REQ-032 Reset deassertion SHALL be followed by BOOT cycle per REQ-017 before first fetch.

Verification
REQ-033 Reset release, PC_Write=1, IM word at 0 = 32'h2008_0005 -> edge1 State=RUN, Instr_addr=0; edge2 IF_ID_Instr=32'h2008_0005, IF_ID_PC4=4, Valid=1, Instr_addr=4, Fetch_count=1.
REQ-034 From PC=8 in RUN, PC_Write=0 for 3 cycles -> PC stays 8, IF/ID frozen, State=HOLD, Stall_count=3; PC_Write=1 -> PC=12, State=RUN.
REQ-035 PC=16, Branch_taken=1, Branch_target=32'h40, Jump=1, Jump_target=32'h80, PC_Write=0 -> PC=0x40, IF_ID_Instr=0, Valid=0, Stall_count unchanged.
REQ-036 Jump_target=32'h0000_0103 -> PC=32'h0000_0100; PC preset 32'hFFFF_FFFC advance -> PC=0, IF_ID_PC4=0.
REQ-037 Stall_count forced near 16'hFFFE, 3 stall cycles -> holds 16'hFFFF; rst_n pulsed low between clock edges -> all outputs zero and State=BOOT before next edge.
